// File: rtl/call_stack.sv
// LIFO return-address/data stack with a registered top-of-stack and a DEPTH-1 entry backing array.
// Optional sticky overflow/underflow flags are enabled by defining STACK_ERR_FLAGS_EN.
module call_stack #(
   parameter int WIDTH = 16,
   parameter int DEPTH = 16
) (
   input  logic                         i_clk,
   input  logic                         i_reset_n,
   input  logic                         i_push,
   input  logic                         i_pop,
   input  logic [WIDTH-1:0]             i_bus_data,
   output logic [WIDTH-1:0]             o_stack_data,
   output logic                         o_empty,
   output logic                         o_full,
   output logic [$clog2(DEPTH+1)-1:0]   o_count
`ifdef STACK_ERR_FLAGS_EN
   ,
   output logic                         o_overflow,
   output logic                         o_underflow,
   input  logic                         i_err_clr
`endif
);

   localparam int CNT_W = $clog2(DEPTH+1);
   localparam int IDX_W = (DEPTH > 2) ? $clog2(DEPTH-1) : 1;

   logic [WIDTH-1:0] top;
   logic [WIDTH-1:0] mem [DEPTH-1];
   logic [CNT_W-1:0] count;
   logic [IDX_W-1:0] wr_idx;
   logic [IDX_W-1:0] rd_idx;
   logic             empty;
   logic             full;
   logic             push_only;
   logic             pop_only;

   always_comb begin
      empty     = (count == '0);
      full      = (count == CNT_W'(DEPTH));
      push_only = i_push && !i_pop;
      pop_only  = i_pop && !i_push;
      wr_idx    = IDX_W'(count - CNT_W'(1));
      rd_idx    = IDX_W'(count - CNT_W'(2));
   end

   // The old top spills into the array only when a push lands on a non-empty, non-full stack.
   always_ff @(posedge i_clk) begin
      if (i_reset_n && push_only && !full && !empty)
         mem[wr_idx] <= top;
   end

   always_ff @(posedge i_clk) begin
      if (!i_reset_n) begin
         count <= '0;
         top   <= '0;
      end else if (i_push && i_pop) begin
         top <= i_bus_data;
         if (empty)
            count <= CNT_W'(1);
      end else if (push_only) begin
         if (!full) begin
            top   <= i_bus_data;
            count <= count + CNT_W'(1);
         end
      end else if (pop_only) begin
         if (count > CNT_W'(1)) begin
            top   <= mem[rd_idx];
            count <= count - CNT_W'(1);
         end else if (count == CNT_W'(1)) begin
            top   <= '0;
            count <= '0;
         end
      end
   end

`ifdef STACK_ERR_FLAGS_EN
   // A new error on the same edge as a clear leaves the flag set.
   always_ff @(posedge i_clk) begin
      if (!i_reset_n) begin
         o_overflow  <= 1'b0;
         o_underflow <= 1'b0;
      end else begin
         if (push_only && full)
            o_overflow <= 1'b1;
         else if (i_err_clr)
            o_overflow <= 1'b0;
         if (i_pop && empty)
            o_underflow <= 1'b1;
         else if (i_err_clr)
            o_underflow <= 1'b0;
      end
   end
`endif

   always_comb begin
      o_stack_data = empty ? '0 : top;
      o_empty      = empty;
      o_full       = full;
      o_count      = count;
   end

endmodule
